// File: rtl/sram_fifo_pkg.sv
// Shared sizing constants for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that turns a single-port synchronous SRAM into a DEPTH-word
// FIFO with valid/ready write and read streams and a registered output word.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          sram_cs,
  output logic          sram_we,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_mem_count;
  logic          r_inflight;
  logic          r_out_valid;
  logic [DW-1:0] r_rd_data;

  logic w_full;
  logic w_rg;
  logic w_wg;

  // Reads win the single SRAM port; the output register must be free or draining.
  assign w_full = (r_mem_count == CW'(DEPTH));
  assign w_rg   = !rst && (r_mem_count != '0) && !r_inflight &&
                  (!r_out_valid || rd_ready);
  assign wr_ready = !rst && !w_full && !w_rg;
  assign w_wg     = wr_valid && wr_ready;

  assign sram_cs   = w_wg | w_rg;
  assign sram_we   = w_wg;
  assign sram_rd   = w_rg;
  assign sram_addr = rst ? '0 : (w_rg ? r_rptr : r_wptr);
  assign sram_din  = rst ? '0 : wr_data;

  assign count    = r_mem_count;
  assign full     = w_full;
  assign empty    = (r_mem_count == '0) && !r_inflight && !r_out_valid;
  assign rd_valid = r_out_valid;
  assign rd_data  = r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_mem_count <= '0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (w_wg) begin
        r_wptr      <= r_wptr + AW'(1);
        r_mem_count <= r_mem_count + CW'(1);
      end else if (w_rg) begin
        r_rptr      <= r_rptr + AW'(1);
        r_mem_count <= r_mem_count - CW'(1);
      end
      // A grant can only be issued with nothing in flight, so this tracks it exactly.
      r_inflight <= w_rg;
      if (r_inflight) begin
        r_rd_data   <= sram_dout;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && rd_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: SRAM model, queue-based reference and directed vectors.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          sram_cs;
  logic          sram_we;
  logic          sram_rd;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  logic [DW-1:0] sram_mem [DEPTH];

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Synchronous single-port SRAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      if (sram_rd) sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every accepted word sits in q until the consumer takes it.
  logic [DW-1:0] q[$];
  int w_cnt, r_cnt, arr, m_cnt;
  bit rv_m, m_rg;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_strobes", {29'd0, sram_cs, sram_we, sram_rd}, 0);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_din", 32'(sram_din), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_empty", 32'(empty), 1);
      q.delete();
      w_cnt = 0; r_cnt = 0; arr = 0; rv_m = 1'b0;
    end else begin
      m_cnt = w_cnt - r_cnt;
      m_rg  = (m_cnt != 0) && (arr == 0) && (!rv_m || rd_ready);
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == int'(DEPTH)));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("rd_valid", 32'(rd_valid), 32'(rv_m));
      if (rv_m && q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
      chk("cs", 32'(sram_cs), 32'(sram_we | sram_rd));
      chk("rd_grant", 32'(sram_rd), 32'(m_rg));
      chk("wr_ready", 32'(wr_ready), 32'(m_cnt < int'(DEPTH) && !m_rg));
      chk("wr_accept", 32'(wr_valid & wr_ready), 32'(sram_we));
      if (sram_we) begin
        chk("wr_addr", 32'(sram_addr), 32'(w_cnt % int'(DEPTH)));
        chk("wr_din", 32'(sram_din), 32'(wr_data));
        q.push_back(sram_din);
        w_cnt++;
      end
      if (sram_rd) chk("rd_addr", 32'(sram_addr), 32'(r_cnt % int'(DEPTH)));
      if (rv_m && rd_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        rv_m = 1'b0;
      end
      if (arr != 0) begin
        arr--;
        if (arr == 0) rv_m = 1'b1;
      end
      if (sram_rd) begin
        r_cnt++;
        arr = 1;
      end
    end
  end

  task automatic push(input logic [DW-1:0] d);
    bit acc = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    chk("push_accept", 32'(acc), 1);
  endtask

  task automatic wait_rv();
    bit got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = rd_valid;
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    chk("wait_rd_valid", 32'(got), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e4 [4];
    logic [DW-1:0] got [4];
    int tc [4];
    int k, acc, n;
    logic [DW-1:0] last, prev;

    e4[0] = 8'h00; e4[1] = 8'h01; e4[2] = 8'h10; e4[3] = 8'h06;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset release
    @(negedge clk);
    chk("rel_empty", 32'(empty), 1);
    chk("rel_wr_ready", 32'(wr_ready), 1);
    chk("rel_rd_valid", 32'(rd_valid), 0);
    chk("rel_strobes", {29'd0, sram_cs, sram_we, sram_rd}, 0);
    @(posedge clk); #1;

    // Four writes with the consumer stalled
    for (int i = 0; i < 4; i++) push(e4[i]);
    @(negedge clk);
    chk("t2_count", 32'(count), 3);
    chk("t2_rd_valid", 32'(rd_valid), 1);
    chk("t2_rd_data", 32'(rd_data), 32'h00);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_mem%0d", i), 32'(sram_mem[i]), 32'(e4[i]));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_hold", 32'(rd_data), 32'h00);
    end
    @(posedge clk); #1;

    // Drain: in order, one word every two cycles
    rd_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (rd_valid) begin
        got[k] = rd_data;
        tc[k]  = cyc;
        k++;
      end
      @(posedge clk); #1;
    end
    chk("t3_words", 32'(k), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_data%0d", i), 32'(got[i]), 32'(e4[i]));
    for (int i = 1; i < 4; i++) chk($sformatf("t3_gap%0d", i), 32'(tc[i] - tc[i-1]), 2);
    @(negedge clk);
    chk("t3_empty", 32'(empty), 1);
    @(posedge clk); #1;
    rd_ready = 1'b0;

    // Fill: 256 resident words plus one in the output register
    acc = 0;
    wr_valid = 1'b1;
    wr_data  = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (wr_ready) acc++;
      @(posedge clk); #1;
      wr_data = DW'(acc);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_accepted", 32'(acc), 257);
    chk("t4_full", 32'(full), 1);
    chk("t4_count", 32'(count), 256);
    chk("t4_wr_ready", 32'(wr_ready), 0);
    chk("t4_rd_data", 32'(rd_data), 32'h00);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_rg", 32'(sram_rd), 1);
    chk("t4_pop_full", 32'(full), 1);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("t4_full_clr", 32'(full), 0);
    chk("t4_count_pop", 32'(count), 255);

    // Read grant and write offered together, then drain across the wrap
    wait_rv();
    @(posedge clk); #1;
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    chk("t5_rd_first", 32'(sram_rd), 1);
    chk("t5_we_stall", 32'(sram_we), 0);
    chk("t5_wr_ready", 32'(wr_ready), 0);
    chk("t5_rd_data", 32'(rd_data), 32'h01);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("t5_we_next", 32'(sram_we), 1);
    chk("t5_waddr", 32'(sram_addr), 32'h05);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0; last = '0; prev = '0;
    for (int i = 0; i < 1200 && n < 256; i++) begin
      @(negedge clk);
      if (rd_valid) begin
        prev = last;
        last = rd_data;
        n++;
      end
      @(posedge clk); #1;
    end
    chk("t5_drained", 32'(n), 256);
    chk("t5_last", 32'(last), 32'hA5);
    chk("t5_prev", 32'(prev), 32'h00);
    @(negedge clk);
    chk("t5_empty", 32'(empty), 1);
    @(posedge clk); #1;
    rd_ready = 1'b0;

    // Reset with a read in flight
    push(8'h5A); push(8'h6B); push(8'h7C);
    wait_rv();
    chk("t6_head", 32'(rd_data), 32'h5A);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("t6_rg", 32'(sram_rd), 1);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_count", 32'(count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(rd_valid), 0);
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    push(8'hD3);
    wait_rv();
    chk("t6_fresh", 32'(rd_data), 32'hD3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_drop", 32'(rd_valid), 0);
    chk("t6_drop_data", 32'(rd_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
